acc_datapath_ext: RTL

Parametrised accumulator datapath: next generation of the team's 4-bit accumulator core. Holds the accumulator, carry flag, PC, general register file (with I/O-mapped registers) and a hardware call/return stack. Executes one control-decoded instruction per enabled cycle. Adds configurable width, register count, conditional branch modes, carry arithmetic, a stall input and call/return. Sits between the instruction decoder and the chip I/O pads.

---
 rtl/acc_datapath_ext_if.sv | 41 ++++
 rtl/acc_datapath_ext.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/acc_datapath_ext_if.sv
// Decoder/pad-side bundle for the accumulator datapath.
// The datapath uses the slave modport; the instruction decoder and pad
// logic use the master modport.
interface acc_datapath_ext_if #(
    parameter int DATA_LEN = 4,
    parameter int PC_LEN   = 8,
    parameter int NUM_REGS = 8
);
    localparam int RID_W = $clog2(NUM_REGS);

    logic                EN;
    logic [PC_LEN-1:0]   PC;
    logic [DATA_LEN-1:0] IPORT;
    logic [DATA_LEN-1:0] OPORT;
    logic [2:0]          ALU_OP;
    logic [DATA_LEN-1:0] INSTR_IMM;
    logic                IMM_SEL;
    logic [PC_LEN-1:0]   BR_TARGET;
    logic                IS_BR;
    logic [1:0]          BR_COND;
    logic                IS_CALL;
    logic                IS_RET;
    logic                IS_LD;
    logic                IS_ST;
    logic [RID_W-1:0]    REG_ID;
    logic                FLAG_Z;
    logic                FLAG_C;
    logic                STACK_ERR;

    modport slave (
        input  EN, IPORT, ALU_OP, INSTR_IMM, IMM_SEL, BR_TARGET, IS_BR,
               BR_COND, IS_CALL, IS_RET, IS_LD, IS_ST, REG_ID,
        output PC, OPORT, FLAG_Z, FLAG_C, STACK_ERR
    );

    modport master (
        output EN, IPORT, ALU_OP, INSTR_IMM, IMM_SEL, BR_TARGET, IS_BR,
               BR_COND, IS_CALL, IS_RET, IS_LD, IS_ST, REG_ID,
        input  PC, OPORT, FLAG_Z, FLAG_C, STACK_ERR
    );
endinterface

// File: rtl/acc_datapath_ext.sv
// Parametrised accumulator datapath: accumulator, carry, PC, register file
// with I/O-mapped registers 0 (output port) and 1 (input port), and a
// hardware return stack. One decoded instruction per enabled cycle.
module acc_datapath_ext #(
    parameter int DATA_LEN    = 4,
    parameter int PC_LEN      = 8,
    parameter int NUM_REGS    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    acc_datapath_ext_if.slave bus
);
    localparam int RID_W  = $clog2(NUM_REGS);
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_LEN-1:0]                   acc_q, acc_d;
    logic                                  c_q, c_d;
    logic [PC_LEN-1:0]                     pc_q, pc_d;
    logic [NUM_REGS-1:0][DATA_LEN-1:0]     regs_q, regs_d;
    logic [STACK_DEPTH-1:0][PC_LEN-1:0]    stk_q, stk_d;
    logic [SP_W-1:0]                       sp_q, sp_d;
    logic                                  err_q, err_d;

    logic [DATA_LEN-1:0] rdata, opb, alu_y;
    logic                alu_c, br_taken;
    logic [DATA_LEN:0]   sum_w;
    logic [PC_LEN-1:0]   pc_inc;
    logic [SP_W-1:0]     sp_dec;
    logic [STK_IW-1:0]   stk_wr_idx, stk_rd_idx;

    assign pc_inc     = pc_q + PC_LEN'(1);
    assign sp_dec     = sp_q - SP_W'(1);
    assign stk_wr_idx = STK_IW'(sp_q);
    assign stk_rd_idx = STK_IW'(sp_dec);

    // Operand B select; register 1 reads straight from the input pads.
    always_comb begin
        rdata = (bus.REG_ID == RID_W'(1)) ? bus.IPORT : regs_q[bus.REG_ID];
        opb   = bus.IMM_SEL ? bus.INSTR_IMM : rdata;
    end

    // ALU: carry is only touched by the arithmetic ops and SHR.
    always_comb begin
        alu_y = acc_q;
        alu_c = c_q;
        sum_w = '0;
        case (bus.ALU_OP)
            3'b000: begin
                sum_w = {1'b0, acc_q} + {1'b0, opb};
                alu_y = sum_w[DATA_LEN-1:0];
                alu_c = sum_w[DATA_LEN];
            end
            3'b001: begin
                sum_w = {1'b0, acc_q} + {1'b0, opb} + {{DATA_LEN{1'b0}}, c_q};
                alu_y = sum_w[DATA_LEN-1:0];
                alu_c = sum_w[DATA_LEN];
            end
            3'b010: begin
                // Top bit of the widened difference is the borrow.
                sum_w = {1'b0, acc_q} - {1'b0, opb};
                alu_y = sum_w[DATA_LEN-1:0];
                alu_c = ~sum_w[DATA_LEN];
            end
            3'b011: alu_y = acc_q & opb;
            3'b100: alu_y = acc_q | opb;
            3'b101: alu_y = acc_q ^ opb;
            3'b110: alu_y = opb;
            default: begin
                alu_y = {1'b0, acc_q[DATA_LEN-1:1]};
                alu_c = acc_q[0];
            end
        endcase
    end

    // Branch condition on the pre-instruction accumulator and carry.
    always_comb begin
        case (bus.BR_COND)
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = acc_q[DATA_LEN-1];
            2'b10:   br_taken = (acc_q == '0);
            default: br_taken = c_q;
        endcase
    end

    // Next-state: strobe priority RET > CALL > BR > ST > LD > ALU.
    always_comb begin
        acc_d  = acc_q;
        c_d    = c_q;
        pc_d   = pc_q;
        regs_d = regs_q;
        stk_d  = stk_q;
        sp_d   = sp_q;
        err_d  = err_q;
        if (bus.EN) begin
            if (bus.IS_RET) begin
                if (sp_q == '0) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    sp_d = sp_dec;
                    pc_d = stk_q[stk_rd_idx];
                end
            end else if (bus.IS_CALL) begin
                pc_d = bus.BR_TARGET;
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    stk_d[stk_wr_idx] = pc_inc;
                    sp_d              = sp_q + SP_W'(1);
                end
            end else if (bus.IS_BR) begin
                pc_d = br_taken ? bus.BR_TARGET : pc_inc;
            end else if (bus.IS_ST) begin
                pc_d = pc_inc;
                if (bus.REG_ID != RID_W'(1))
                    regs_d[bus.REG_ID] = acc_q;
            end else if (bus.IS_LD) begin
                pc_d  = pc_inc;
                acc_d = rdata;
            end else begin
                pc_d  = pc_inc;
                acc_d = alu_y;
                c_d   = alu_c;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc_q  <= '0;
            c_q    <= 1'b0;
            pc_q   <= '0;
            regs_q <= '0;
            stk_q  <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            c_q    <= c_d;
            pc_q   <= pc_d;
            regs_q <= regs_d;
            stk_q  <= stk_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.OPORT     = regs_q[0];
    assign bus.FLAG_Z    = (acc_q == '0);
    assign bus.FLAG_C    = c_q;
    assign bus.STACK_ERR = err_q;
endmodule
